// File: rtl/outer_prod_acc.sv
// 4x4 outer-product accumulator: sums k_len product vectors per element,
// then streams the finished 16-element tile out one element per handshake.
module outer_prod_acc #(
  parameter int NR = 4,
  parameter int NC = 4,
  parameter int PW = 32,
  parameter int AW = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  k_len,
  input  logic                        prod_valid,
  output logic                        prod_ready,
  input  logic [NR*NC-1:0][PW-1:0]    prod,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AW-1:0]               out_data,
  output logic [3:0]                  out_idx,
  output logic                        out_last,
  output logic                        busy
);

  localparam int NE = NR * NC;
  localparam logic [3:0] LAST = 4'(NE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NE-1:0][AW-1:0]  acc_q, acc_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;

  logic in_idle, in_acc, in_drain;

  assign in_idle  = (state_q == S_IDLE);
  assign in_acc   = (state_q == S_ACC);
  assign in_drain = (state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (1'b1)
      in_idle: begin
        if (start && (k_len != 8'd0)) begin
          acc_d   = '0;
          cnt_d   = k_len;
          state_d = S_ACC;
        end
      end
      in_acc: begin
        if (prod_valid) begin
          for (int n = 0; n < NE; n++) begin
            acc_d[n] = acc_q[n] + {{(AW-PW){1'b0}}, prod[n]};
          end
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            idx_d   = 4'd0;
            state_d = S_DRAIN;
          end
        end
      end
      in_drain: begin
        if (out_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs depend on registered state only; data is masked outside DRAIN.
  assign prod_ready = in_acc;
  assign out_valid  = in_drain;
  assign out_data   = in_drain ? acc_q[idx_q] : '0;
  assign out_idx    = idx_q;
  assign out_last   = in_drain && (idx_q == LAST);
  assign busy       = !in_idle;

endmodule

// File: tb/tb_outer_prod_acc.sv
// Directed bench for outer_prod_acc: reset, single beat, stalls,
// drain backpressure, max length and mid-tile reset.
module tb_outer_prod_acc;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        k_len;
  logic              prod_valid;
  logic              prod_ready;
  logic [15:0][31:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [39:0]       out_data;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              busy;

  int vecs = 0;
  int errs = 0;

  outer_prod_acc dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_prod(input logic [31:0] v);
    for (int n = 0; n < 16; n++) prod[n] = v;
  endtask

  task automatic beat(input logic [31:0] v);
    set_prod(v);
    prod_valid = 1'b1;
    step();
    prod_valid = 1'b0;
  endtask

  // Drains one tile; expected element h = base + h*inc.
  task automatic drain(input logic [39:0] base, input logic [39:0] inc,
                       input bit bp, input bit sp);
    int h;
    int cyc;
    h = 0;
    cyc = 0;
    while (h < 16 && cyc < 100) begin
      chk("d_valid", 64'(out_valid), 64'd1);
      chk("d_data", 64'(out_data), 64'(base + 40'(h) * inc));
      chk("d_idx", 64'(out_idx), 64'(h));
      chk("d_last", 64'(out_last), 64'(h == 15));
      chk("d_ready", 64'(prod_ready), 64'd0);
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      start = sp;
      k_len = 8'd1;
      step();
      if (out_ready) h++;
      cyc++;
    end
    out_ready = 1'b0;
    start = 1'b0;
    chk("d_count", 64'(h), 64'd16);
    chk("d_busy_end", 64'(busy), 64'd0);
    chk("d_valid_end", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    k_len = 8'd0;
    prod_valid = 1'b0;
    out_ready = 1'b0;
    set_prod(32'd0);
    step();
    step();
    rst = 1'b0;

    chk("rst_ready", 64'(prod_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // k_len = 0 must be ignored
    start = 1'b1;
    k_len = 8'd0;
    step();
    start = 1'b0;
    chk("k0_busy", 64'(busy), 64'd0);
    chk("k0_ready", 64'(prod_ready), 64'd0);
    step();
    chk("k0_busy2", 64'(busy), 64'd0);

    // single beat, prod[n] = n+1
    start = 1'b1;
    k_len = 8'd1;
    step();
    start = 1'b0;
    chk("sb_ready", 64'(prod_ready), 64'd1);
    chk("sb_busy", 64'(busy), 64'd1);
    chk("sb_nvalid", 64'(out_valid), 64'd0);
    for (int n = 0; n < 16; n++) prod[n] = 32'(n + 1);
    prod_valid = 1'b1;
    step();
    prod_valid = 1'b0;
    drain(40'd1, 40'd1, 1'b0, 1'b0);

    // three beats with two idle cycles between, backpressured drain
    start = 1'b1;
    k_len = 8'd3;
    step();
    start = 1'b0;
    beat(32'd5);
    step();
    step();
    chk("st_ready", 64'(prod_ready), 64'd1);
    chk("st_nvalid", 64'(out_valid), 64'd0);
    beat(32'd7);
    step();
    step();
    chk("st_ready2", 64'(prod_ready), 64'd1);
    beat(32'hFFFF_FFFF);
    drain(40'h01_0000_000B, 40'd0, 1'b1, 1'b0);

    // maximum length with start pulses in ACC and DRAIN
    start = 1'b1;
    k_len = 8'd255;
    step();
    set_prod(32'hFFFF_FFFF);
    prod_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      start = (i % 2 == 0);
      k_len = 8'd1;
      step();
      if (i == 253) begin
        chk("mx_acc", 64'(prod_ready), 64'd1);
        chk("mx_nvalid", 64'(out_valid), 64'd0);
      end
    end
    prod_valid = 1'b0;
    start = 1'b0;
    drain(40'hFE_FFFF_FF01, 40'd0, 1'b0, 1'b1);
    chk("mx_idle_ready", 64'(prod_ready), 64'd0);

    // reset at the second beat of a k_len = 4 tile
    start = 1'b1;
    k_len = 8'd4;
    step();
    start = 1'b0;
    beat(32'd9);
    set_prod(32'd9);
    prod_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    prod_valid = 1'b0;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ready", 64'(prod_ready), 64'd0);
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_data", 64'(out_data), 64'd0);
    step();
    step();
    chk("mr_valid2", 64'(out_valid), 64'd0);

    start = 1'b1;
    k_len = 8'd1;
    step();
    start = 1'b0;
    beat(32'd2);
    drain(40'd2, 40'd0, 1'b0, 1'b0);

    // back-to-back start right after the final handshake
    start = 1'b1;
    k_len = 8'd1;
    step();
    start = 1'b0;
    chk("bb_ready", 64'(prod_ready), 64'd1);
    chk("bb_busy", 64'(busy), 64'd1);
    beat(32'd3);
    drain(40'd3, 40'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/outer_prod_acc.md
# outer_prod_acc

Accumulates the 16 partial products of the 4x4 weight-by-input multiplier array over k_len successive product vectors. Each product vector adds into 16 per-element accumulators. When the tile is complete, the block drains the finished 4x4 output tile one element per handshake. It sits directly downstream of the multiplier array: the array's 16x32-bit product bus feeds prod, and the serial result stream feeds the writeback path.

## Interface
Parameters:
- NR, 4, rows (weights per vector)
- NC, 4, columns (inputs per vector)
- PW, 32, product width
- AW, 40, accumulator width (PW + 8; cannot overflow for k_len <= 255)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new tile; sampled only in IDLE
- k_len  in  8  number of product vectors to accumulate; sampled with start
- prod_valid  in  1  product vector valid
- prod_ready  out  1  block accepts a product vector
- prod  in  [NR*NC-1:0][PW-1:0]  products; element n = NC*row + col, unsigned
- out_valid  out  1  out_data holds a finished element
- out_ready  in  1  downstream accepts the element
- out_data  out  AW  accumulated element
- out_idx  out  4  element index 0..15, same n mapping as prod
- out_last  out  1  high with out_valid when out_idx = 15
- busy  out  1  state != IDLE

## Operation
- Three states: IDLE, ACC, DRAIN.
- Registers: state; acc[0..15] (AW bits each); cnt (8 bits); idx (4 bits).
- **IDLE:**
  - prod_ready = 0, out_valid = 0.
  - start=1 with k_len != 0: clear all acc to 0, cnt <= k_len, go to ACC.
  - start=1 with k_len = 0: ignored; stay in IDLE.
- **ACC:**
  - prod_ready = 1.
  - On prod_valid (beat accepted): acc[n] <= acc[n] + zero-extended prod[n] for all 16 elements in parallel; cnt <= cnt - 1.
  - Beat accepted with cnt = 1: go to DRAIN, idx <= 0.
  - prod_valid=0: hold all state.
- **DRAIN:**
  - prod_ready = 0, out_valid = 1.
  - out_data = acc[idx], out_idx = idx, out_last = (idx == 15).
  - On out_ready: idx <= idx + 1.
  - Handshake with idx = 15: go to IDLE.
  - out_ready=0: outputs hold stable.
- start is ignored in ACC and DRAIN; an in-progress tile is never aborted except by rst.
- Arithmetic is unsigned, modulo 2^AW. With default widths the maximum sum is 255 * (2^32 - 1) < 2^40, so no wrap occurs.
- acc contents persist after DRAIN until the next accepted start.

## Timing
- Reset (rst=1 at a clock edge) forces the following, regardless of state:
  - state = IDLE, acc = 0, cnt = 0, idx = 0.
  - Next cycle: prod_ready = 0, out_valid = 0, out_last = 0, out_data = 0, out_idx = 0, busy = 0.
- rst mid-ACC or mid-DRAIN discards the tile; no partial output is produced afterwards.
- start sampled at edge T: ACC from T+1; prod_ready high in cycle T+1.
- Accumulate latency is 1 cycle: a beat accepted at edge T is visible in acc at T+1.
- Last beat accepted at edge T: out_valid = 1 with element 0 in cycle T+1. No idle cycle.
- Drain takes 16 cycles minimum (out_ready held high); one element per accepted handshake.
- Last handshake at edge T: IDLE and busy = 0 in cycle T+1. A start in cycle T+1 is accepted.
- Minimum tile time: 1 (start) + k_len + 16 cycles.
- All outputs are functions of registered state only. No combinational path from prod_valid or out_ready to any output.

## Test plan
- **Reset values:** after rst, all outputs 0. start with k_len=0 -> busy stays 0 and prod_ready stays 0.
- **Single beat:** k_len=1, prod[n] = n+1, out_ready=1 -> out_valid the cycle after the beat. Stream 1,2,...,16 with out_idx 0..15, out_last only on idx 15, busy drops the next cycle.
- **Accumulation with stalls:** k_len=3, beats of all 5, all 7, all 0xFFFFFFFF, with prod_valid low 2 cycles between beats -> every element = 12 + 0xFFFFFFFF = 0x010000000B.
- **Drain backpressure:** out_ready toggling 1,0,0,1,... -> out_data/out_idx hold while stalled. Exactly 16 handshakes, no duplicates or skips.
- **Maximum length:** k_len=255, every prod = 0xFFFFFFFF -> each element = 0xFEFFFFFF01, no overflow. start pulses during ACC and DRAIN are ignored.
- **Reset mid-operation:** rst at the 2nd beat of k_len=4, then a new start with k_len=1 and prod[n] = 2 -> all outputs = 2 (old sums discarded). Back-to-back start the cycle after out_last is accepted.
